lbdr_route_unit: RTL and testbench

Parametrised, handshaked successor to the single-register LBDR port selector. It sits between an input-port FIFO and the switch allocator of a mesh router. It computes the output port from a packet's HEADER flit and holds a one-hot request for the whole packet, from header through TAIL. It also drops unroutable or orphan flits cleanly and counts delivered packets.

---
 rtl/lbdr_route_unit.sv | 152 +++++++++++++++
 tb/tb_lbdr_route_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lbdr_route_unit.sv
// LBDR route unit: routes a packet from its HEADER flit and holds a one-hot request until TAIL.
// Optional build macro LBDR_ADAPTIVE_EN selects toggle-based choice between two candidates.
module lbdr_route_unit #(
   parameter int unsigned COORD_W = 2,
   parameter logic [7:0]  RXY_RST = 8'h3C,
   parameter logic [3:0]  CX_RST  = 4'hF,
   parameter int unsigned CUR_RST = 5,
   parameter int unsigned CNT_W   = 16,
   localparam int unsigned ADDR_W = 2 * COORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [7:0]        cfg_rxy,
   input  logic [3:0]        cfg_cx,
   input  logic [ADDR_W-1:0] cfg_cur,
   input  logic              flit_valid,
   input  logic [2:0]        flit_id,
   input  logic [ADDR_W-1:0] dst_addr,
   output logic              flit_ready,
   output logic [4:0]        req,
   input  logic              grant,
   output logic              route_err,
   output logic [CNT_W-1:0]  pkt_cnt
);

   localparam logic [2:0] HEADER = 3'b001;
   localparam logic [2:0] TAIL   = 3'b100;

   typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

   state_t            state;
   logic [7:0]        rxy;
   logic [3:0]        cx;
   logic [ADDR_W-1:0] cur;
   logic              err_q;
`ifdef LBDR_ADAPTIVE_EN
   logic              toggle;
`endif

   logic [COORD_W-1:0] x_dst, y_dst, x_cur, y_cur;
   logic               go_n, go_e, go_w, go_s;
   logic [4:0]         cand;
   logic [4:0]         sel;
   logic               is_header, is_tail;

   assign x_dst = dst_addr[COORD_W-1:0];
   assign y_dst = dst_addr[ADDR_W-1:COORD_W];
   assign x_cur = cur[COORD_W-1:0];
   assign y_cur = cur[ADDR_W-1:COORD_W];

   assign go_n = (y_dst < y_cur);
   assign go_s = (y_dst > y_cur);
   assign go_e = (x_dst > x_cur);
   assign go_w = (x_dst < x_cur);

   // rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, cx = {Cs,Cw,Ce,Cn}
   assign cand[0] = ((go_n & ~go_e & ~go_w) | (go_n & go_e & rxy[0]) | (go_n & go_w & rxy[1])) & cx[0];
   assign cand[1] = ((go_e & ~go_n & ~go_s) | (go_e & go_n & rxy[2]) | (go_e & go_s & rxy[3])) & cx[1];
   assign cand[2] = ((go_w & ~go_n & ~go_s) | (go_w & go_n & rxy[4]) | (go_w & go_s & rxy[5])) & cx[2];
   assign cand[3] = ((go_s & ~go_e & ~go_w) | (go_s & go_e & rxy[6]) | (go_s & go_w & rxy[7])) & cx[3];
   assign cand[4] = ~go_n & ~go_e & ~go_w & ~go_s;

`ifdef LBDR_ADAPTIVE_EN
   // Candidates never exceed two, so "second in N,E,W,S order" is the higher set bit.
   function automatic logic [4:0] select_port(input logic [4:0] c, input logic tog);
      logic [4:0] low;
      low = c & (~c + 5'd1);
      if (tog && ($countones(c) == 2)) return c & ~low;
      return low;
   endfunction

   assign sel = select_port(cand, toggle);
`else
   function automatic logic [4:0] select_port(input logic [4:0] c);
      if (c[0])      return 5'b00001;
      else if (c[1]) return 5'b00010;
      else if (c[2]) return 5'b00100;
      else if (c[3]) return 5'b01000;
      else if (c[4]) return 5'b10000;
      return 5'b00000;
   endfunction

   assign sel = select_port(cand);
`endif

   assign is_header = (flit_id == HEADER);
   assign is_tail   = (flit_id == TAIL);

   always_comb begin
      flit_ready = 1'b0;
      unique case (state)
         IDLE:    flit_ready = flit_valid & ~is_header;
         ACTIVE:  flit_ready = flit_valid & grant;
         DROP:    flit_ready = 1'b1;
         default: flit_ready = 1'b0;
      endcase
   end

   // Orphan flits report in their own handshake cycle; unroutable headers one cycle later.
   assign route_err = err_q | ((state == IDLE) & flit_valid & ~is_header);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         req     <= '0;
         err_q   <= 1'b0;
         pkt_cnt <= '0;
         rxy     <= RXY_RST;
         cx      <= CX_RST;
         cur     <= CUR_RST[ADDR_W-1:0];
`ifdef LBDR_ADAPTIVE_EN
         toggle  <= 1'b0;
`endif
      end else begin
         err_q <= 1'b0;
         if (cfg_we) begin
            rxy <= cfg_rxy;
            cx  <= cfg_cx;
            cur <= cfg_cur;
         end
         unique case (state)
            IDLE: begin
               if (flit_valid && is_header) begin
                  if (|cand) begin
                     req   <= sel;
                     state <= ACTIVE;
`ifdef LBDR_ADAPTIVE_EN
                     toggle <= ~toggle;
`endif
                  end else begin
                     err_q <= 1'b1;
                     state <= DROP;
                  end
               end
            end
            ACTIVE: begin
               if (flit_valid && grant && is_tail) begin
                  req   <= '0;
                  state <= IDLE;
                  if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
               end
            end
            DROP: begin
               if (flit_valid && is_tail) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lbdr_route_unit.sv
// Randomised and directed bench for lbdr_route_unit against a behavioural packet-level model.
module tb_lbdr_route_unit;

   localparam logic [2:0] HDR  = 3'b001;
   localparam logic [2:0] BODY = 3'b010;
   localparam logic [2:0] TAIL = 3'b100;
   localparam int CW = 4;

`ifdef LBDR_ADAPTIVE_EN
   localparam logic [4:0] SECOND_DST0 = 5'b00100;
`else
   localparam logic [4:0] SECOND_DST0 = 5'b00001;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [7:0]    cfg_rxy = 8'h00;
   logic [3:0]    cfg_cx = 4'h0;
   logic [3:0]    cfg_cur = 4'h0;
   logic          flit_valid = 1'b0;
   logic [2:0]    flit_id = 3'b000;
   logic [3:0]    dst_addr = 4'h0;
   logic          flit_ready;
   logic [4:0]    req;
   logic          grant = 1'b0;
   logic          route_err;
   logic [CW-1:0] pkt_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Model: packet phase 0=idle, 1=forwarding, 2=dropping.
   int            m_phase;
   logic [4:0]    m_req;
   logic          m_err;
   int            m_cnt;
   logic [7:0]    m_rxy;
   logic [3:0]    m_cx;
   logic [3:0]    m_cur;
`ifdef LBDR_ADAPTIVE_EN
   logic          m_tog;
`endif

   lbdr_route_unit #(.COORD_W(2), .RXY_RST(8'h3C), .CX_RST(4'hF), .CUR_RST(5), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx),
      .cfg_cur(cfg_cur), .flit_valid(flit_valid), .flit_id(flit_id), .dst_addr(dst_addr),
      .flit_ready(flit_ready), .req(req), .grant(grant), .route_err(route_err), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Port index 0..3 = N,E,W,S; result is the one-hot request or 0 if unroutable.
   function automatic logic [4:0] model_route(input logic [3:0] d);
      int xc, yc, xd, yd;
      bit n, s, e, w, horiz, vert;
      int list[$];
      xc = int'(m_cur[1:0]); yc = int'(m_cur[3:2]);
      xd = int'(d[1:0]);     yd = int'(d[3:2]);
      n = yd < yc; s = yd > yc; e = xd > xc; w = xd < xc;
      horiz = e | w; vert = n | s;
      if (!horiz && !vert) return 5'b10000;
      if (n && m_cx[0] && (!horiz || (e ? m_rxy[0] : m_rxy[1]))) list.push_back(0);
      if (e && m_cx[1] && (!vert  || (n ? m_rxy[2] : m_rxy[3]))) list.push_back(1);
      if (w && m_cx[2] && (!vert  || (n ? m_rxy[4] : m_rxy[5]))) list.push_back(2);
      if (s && m_cx[3] && (!horiz || (e ? m_rxy[6] : m_rxy[7]))) list.push_back(3);
      if (list.size() == 0) return 5'b00000;
`ifdef LBDR_ADAPTIVE_EN
      if (list.size() == 2 && m_tog) return 5'(1) << list[1];
`endif
      return 5'(1) << list[0];
   endfunction

   task automatic model_update();
      logic [4:0] r;
      if (rst) begin
         m_phase = 0; m_req = '0; m_err = 1'b0; m_cnt = 0;
         m_rxy = 8'h3C; m_cx = 4'hF; m_cur = 4'd5;
`ifdef LBDR_ADAPTIVE_EN
         m_tog = 1'b0;
`endif
      end else begin
         r = model_route(dst_addr);
         m_err = 1'b0;
         if (m_phase == 0 && flit_valid && flit_id == HDR) begin
            if (r != 0) begin
               m_req = r; m_phase = 1;
`ifdef LBDR_ADAPTIVE_EN
               m_tog = ~m_tog;
`endif
            end else begin
               m_err = 1'b1; m_phase = 2;
            end
         end else if (m_phase == 1 && flit_valid && grant && flit_id == TAIL) begin
            m_req = '0; m_phase = 0;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
         end else if (m_phase == 2 && flit_valid && flit_id == TAIL) begin
            m_phase = 0;
         end
         if (cfg_we) begin
            m_rxy = cfg_rxy; m_cx = cfg_cx; m_cur = cfg_cur;
         end
      end
   endtask

   // One clock: compare outputs mid-cycle, then advance the model on the edge.
   task automatic step();
      logic exp_ready, exp_err;
      @(negedge clk);
      if (!rst) begin
         exp_ready = (m_phase == 0) ? (flit_valid && flit_id != HDR) :
                     (m_phase == 1) ? (flit_valid && grant) : 1'b1;
         exp_err   = m_err | (m_phase == 0 && flit_valid && flit_id != HDR);
         check("flit_ready", 32'(flit_ready), 32'(exp_ready));
         check("route_err", 32'(route_err), 32'(exp_err));
         check("req", 32'(req), 32'(m_req));
         check("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic flit(input logic v, input logic [2:0] id, input logic [3:0] d, input logic g);
      rst = 1'b0; cfg_we = 1'b0;
      flit_valid = v; flit_id = id; dst_addr = d; grant = g;
      step();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; cfg_we = 1'b0; flit_valid = 1'b0; grant = 1'b0;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic do_cfg(input logic [7:0] rxy, input logic [3:0] cx, input logic [3:0] cur);
      rst = 1'b0; cfg_we = 1'b1; cfg_rxy = rxy; cfg_cx = cx; cfg_cur = cur;
      flit_valid = 1'b0; grant = 1'b0;
      step();
      cfg_we = 1'b0;
   endtask

   initial begin
      do_reset(2);
      flit(0, BODY, 0, 0);
      check("rst_req", 32'(req), 32'h0);
      check("rst_cnt", 32'(pkt_cnt), 32'h0);

      // Packet east: header, body, tail
      flit(1, HDR, 4'd7, 1);
      check("east_req", 32'(req), 32'h02);
      flit(1, HDR, 4'd7, 1);
      flit(1, BODY, 4'd0, 1);
      flit(1, TAIL, 4'd0, 1);
      check("east_done_req", 32'(req), 32'h0);
      check("east_cnt", 32'(pkt_cnt), 32'h1);

      // Local delivery, then N+W resolved to W by Rwn
      flit(1, HDR, 4'd5, 1);
      check("local_req", 32'(req), 32'h10);
      flit(1, TAIL, 4'd0, 1);
      flit(1, HDR, 4'd0, 1);
      check("nw_req", 32'(req), 32'h04);
      flit(1, TAIL, 4'd0, 1);

      // East link disconnected: header dropped with its packet
      do_cfg(8'h3C, 4'b1101, 4'd5);
      flit(1, HDR, 4'd7, 1);
      check("drop_req", 32'(req), 32'h0);
      flit(1, BODY, 4'd0, 0);
      flit(1, TAIL, 4'd0, 0);
      check("drop_cnt", 32'(pkt_cnt), 32'h3);

      // Orphan body in idle
      flit(1, BODY, 4'd0, 0);
      flit(0, BODY, 4'd0, 0);

      // Two-candidate headers with all turns permitted
      do_reset(1);
      do_cfg(8'hFF, 4'hF, 4'd5);
      flit(1, HDR, 4'd0, 1);
      check("two_cand_1", 32'(req), 32'h01);
      flit(1, TAIL, 4'd0, 1);
      flit(1, HDR, 4'd0, 1);
      check("two_cand_2", 32'(req), 32'(SECOND_DST0));
      flit(1, TAIL, 4'd0, 1);

      // Stall mid-packet then reset
      flit(1, HDR, 4'd7, 1);
      flit(1, HDR, 4'd7, 1);
      repeat (3) flit(1, BODY, 4'd0, 0);
      check("stall_req", 32'(req), 32'h02);
      rst = 1'b1; flit_valid = 1'b1; flit_id = BODY; step();
      check("post_rst_req", 32'(req), 32'h0);
      check("post_rst_cnt", 32'(pkt_cnt), 32'h0);
      flit(1, BODY, 4'd0, 1);
      flit(1, TAIL, 4'd0, 1);
      flit(1, HDR, 4'd0, 1);
      check("post_rst_route", 32'(req), 32'h04);
      flit(1, TAIL, 4'd0, 1);

      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 299) == 0);
         cfg_we     = ($urandom_range(0, 39) == 0);
         cfg_rxy    = 8'($urandom);
         cfg_cx     = 4'($urandom);
         cfg_cur    = 4'($urandom);
         flit_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0:       flit_id = HDR;
            1, 2, 3: flit_id = BODY;
            default: flit_id = TAIL;
         endcase
         dst_addr   = 4'($urandom);
         grant      = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
